// File: rtl/sw_pkg.sv
// sw_pkg: shared event type and lowest-set-bit helper for the switch event reader.
package sw_pkg;
   localparam int N_SW_DEFAULT = 8;
   localparam int IDX_W = $clog2(N_SW_DEFAULT);
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             rise;
   } sw_evt_t;
   function automatic logic [IDX_W-1:0] lsb_idx(input logic [N_SW_DEFAULT-1:0] v);
      lsb_idx = '0;
      for (int i = N_SW_DEFAULT - 1; i >= 0; i--)
         if (v[i]) lsb_idx = IDX_W'(i);
   endfunction
endpackage

// File: rtl/sw_evt_fifo.sv
// sw_evt_fifo: synchronous event FIFO; a push is accepted while full if a pop happens in the same cycle.
module sw_evt_fifo import sw_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  sw_evt_t                din,
   output sw_evt_t                dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   sw_evt_t mem_q [DEPTH];
   sw_evt_t mem_d [DEPTH];
   always_comb begin
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      mem_d = mem_q;
      if (push) mem_d[wr_q[AW-1:0]] = din;
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   assign count = wr_q - rd_q;
   assign full  = count == (AW + 1)'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/sw_event_reader.sv
// sw_event_reader: synchronizes slide switches and queues each level change as an event.
// Define SW_DEBOUNCE_EN for tick-based debounce; otherwise level follows the synchronizer.
module sw_event_reader import sw_pkg::*; #(
   parameter int N_SW         = N_SW_DEFAULT,
   parameter int TICK_DIV     = 5000000,
   parameter int STABLE_TICKS = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_SW-1:0]         sw,
   output logic [N_SW-1:0]         level,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(N_SW)-1:0] evt_idx,
   output logic                    evt_rise,
   output logic                    evt_ovf,
   input  logic                    ovf_clr
);
   localparam int IW = $clog2(N_SW);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   if (N_SW != N_SW_DEFAULT || TICK_DIV < 1 || STABLE_TICKS < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("sw_event_reader: unsupported parameter set");
   end
   logic [N_SW-1:0] s1_q, s1_d, sync_q, sync_d, level_q, level_d, pend_q, pend_d, chg, clr;
   logic            ovf_q, ovf_d, push, pop, full, empty;
   logic [IW-1:0]   sel;
   logic [FW-1:0]   count;
   sw_evt_t         din, head;
`ifdef SW_DEBOUNCE_EN
   localparam int CW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(STABLE_TICKS + 1);
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   dc_q [N_SW];
   logic [DW-1:0]   dc_d [N_SW];
   logic            tick;
   logic [N_SW-1:0] hit;
   always_comb begin
      tick = cnt_q == CW'(TICK_DIV - 1);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      hit = '0;
      for (int i = 0; i < N_SW; i++) begin
         hit[i] = tick && sync_q[i] != level_q[i] && dc_q[i] == DW'(STABLE_TICKS - 1);
         dc_d[i] = (sync_q[i] == level_q[i] || hit[i]) ? '0 : tick ? dc_q[i] + 1'b1 : dc_q[i];
      end
      level_d = level_q ^ hit;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         dc_q  <= '{default: '0};
      end else begin
         cnt_q <= cnt_d;
         dc_q  <= dc_d;
      end
   end
`else
   always_comb level_d = sync_q;
`endif
   // A change on a bit whose previous event is still unqueued is merged and flagged.
   always_comb begin
      s1_d   = sw;
      sync_d = s1_q;
      chg    = level_d ^ level_q;
      sel    = lsb_idx(pend_q);
      pop    = evt_ready && count != '0;
      push   = |pend_q && (!full || pop);
      clr    = push ? (N_SW'(1) << sel) : '0;
      pend_d = (pend_q & ~clr) | chg;
      ovf_d  = |(chg & pend_q & ~clr) || (ovf_q && !ovf_clr);
      din    = '{idx: sel, rise: level_q[sel]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= '0;
         sync_q  <= '0;
         level_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end
   sw_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign level     = level_q;
   assign evt_valid = !empty;
   assign evt_idx   = empty ? '0 : head.idx;
   assign evt_rise  = !empty && head.rise;
   assign evt_ovf   = ovf_q;
endmodule

// File: tb/tb_sw_event_reader.sv
// tb_sw_event_reader: directed self-checking bench for sw_event_reader, covering both SW_DEBOUNCE_EN builds.
module tb_sw_event_reader;
   localparam int LIM = 40;
`ifdef SW_DEBOUNCE_EN
   localparam int SETTLE = 24;
`else
   localparam int SETTLE = 10;
`endif
   logic       clk = 1'b0, rst = 1'b1, evt_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] sw = 8'h00, level;
   logic       evt_valid, evt_rise, evt_ovf;
   logic [2:0] evt_idx;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   sw_event_reader #(.N_SW(8), .TICK_DIV(4), .STABLE_TICKS(3), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .level     (level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_idx   (evt_idx),
      .evt_rise  (evt_rise),
      .evt_ovf   (evt_ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic do_reset(input logic [7:0] v);
      @(negedge clk);
      rst = 1'b1; sw = v; evt_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_lvl(input logic [7:0] m, input logic [7:0] v, output int n);
      n = 0;
      while ((level & m) != v && n < LIM) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; sw = 8'hFF; evt_ready = 1'b1; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({level, evt_valid, evt_idx, evt_rise, evt_ovf} !== 14'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {level, evt_valid, evt_idx, evt_rise, evt_ovf});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_rise;
      int n;
      do_reset(8'h00);
      repeat (2) @(negedge clk);
      sw = 8'h04;
      wait_lvl(8'h04, 8'h04, n);
`ifdef SW_DEBOUNCE_EN
      checks++;
      if (n < 11 || n > 14) begin
         failures++;
         $display("FAIL rise_latency got=%0d exp=11..14", n);
      end
`else
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL rise_latency got=%0d exp=3", n);
      end
`endif
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_with_level got=%b exp=0", evt_valid);
      end
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd2, 1'b1}) begin
         failures++;
         $display("FAIL single_event got=%b/%0d/%b exp=1/2/1", evt_valid, evt_idx, evt_rise);
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_pop got=%b exp=0", evt_valid);
      end
      sw = 8'h00;
      wait_lvl(8'h04, 8'h00, n);
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd2, 1'b0}) begin
         failures++;
         $display("FAIL fall_event got=%b/%0d/%b exp=1/2/0", evt_valid, evt_idx, evt_rise);
      end
   endtask

   task automatic test_empty_ready;
      int n;
      do_reset(8'h00);
      evt_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL empty_ready_ignored got=%b exp=0", evt_valid);
      end
      sw = 8'h02;
      wait_lvl(8'h02, 8'h02, n);
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd1, 1'b1}) begin
         failures++;
         $display("FAIL event_after_empty got=%b/%0d/%b exp=1/1/1", evt_valid, evt_idx, evt_rise);
      end
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL ready_pop got=%b exp=0", evt_valid);
      end
      evt_ready = 1'b0;
   endtask

`ifdef SW_DEBOUNCE_EN
   task automatic test_bounce;
      int   n;
      logic seen;
      seen = 1'b0;
      do_reset(8'h00);
      for (int k = 0; k < 8; k++) begin
         sw[0] = ~sw[0];
         repeat (5) begin
            @(negedge clk);
            if (evt_valid || level[0]) seen = 1'b1;
         end
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL bounce_no_event got=%b exp=0", seen);
      end
      sw[0] = 1'b1;
      wait_lvl(8'h01, 8'h01, n);
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL bounce_rise got=%b/%0d/%b exp=1/0/1", evt_valid, evt_idx, evt_rise);
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      repeat (SETTLE) @(negedge clk);
      checks++;
      if ({evt_valid, evt_ovf} !== 2'b00) begin
         failures++;
         $display("FAIL bounce_single_event got=%b exp=00", {evt_valid, evt_ovf});
      end
   endtask
`endif

   task automatic test_simultaneous;
      int n;
      do_reset(8'h00);
      sw = 8'hFF;
      wait_lvl(8'hFF, 8'hFF, n);
      repeat (6) @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL stall_head got=%b/%0d/%b exp=1/0/1", evt_valid, evt_idx, evt_rise);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL stall_hold got=%b/%0d/%b exp=1/0/1", evt_valid, evt_idx, evt_rise);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({evt_valid, evt_idx, evt_rise} !== {1'b1, 3'(k), 1'b1}) begin
            failures++;
            $display("FAIL drain_%0d got=%b/%0d/%b exp=1/%0d/1", k, evt_valid, evt_idx, evt_rise, k);
         end
         @(negedge clk);
      end
      checks++;
      if ({evt_valid, evt_ovf} !== 2'b00) begin
         failures++;
         $display("FAIL drain_empty got=%b exp=00", {evt_valid, evt_ovf});
      end
      evt_ready = 1'b0;
   endtask

   task automatic test_overflow;
      int         n;
      logic [3:0] exp_ev [5];
      exp_ev = '{4'h1, 4'h3, 4'h5, 4'h7, 4'hE};
      do_reset(8'h00);
      sw = 8'h0F;
      repeat (SETTLE) @(negedge clk);
      sw = 8'h8F;
      wait_lvl(8'h80, 8'h80, n);
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_ovf} !== {1'b1, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL ovf_before_loss got=%b/%0d/%b exp=1/0/0", evt_valid, evt_idx, evt_ovf);
      end
      sw = 8'h0F;
      wait_lvl(8'h80, 8'h00, n);
      @(negedge clk);
      checks++;
      if (evt_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got=%b exp=1", evt_ovf);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({evt_valid, evt_idx, evt_rise} !== {1'b1, exp_ev[k]}) begin
            failures++;
            $display("FAIL ovf_drain_%0d got=%b/%0d/%b exp=1/%0d/%b", k, evt_valid, evt_idx, evt_rise, exp_ev[k][3:1], exp_ev[k][0]);
         end
         @(negedge clk);
      end
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_drain_empty got=%b exp=0", evt_valid);
      end
      checks++;
      if (evt_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", evt_ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (evt_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear got=%b exp=0", evt_ovf);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      do_reset(8'h00);
      sw = 8'h07;
      repeat (SETTLE) @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx} !== {1'b1, 3'd0}) begin
         failures++;
         $display("FAIL three_queued got=%b/%0d exp=1/0", evt_valid, evt_idx);
      end
      rst = 1'b1;
      sw = 8'h01;
      @(negedge clk);
      checks++;
      if ({evt_valid, level} !== 9'h0) begin
         failures++;
         $display("FAIL mid_reset_clear got=%h exp=0", {evt_valid, level});
      end
      rst = 1'b0;
      wait_lvl(8'h01, 8'h01, n);
      @(negedge clk);
      checks++;
      if ({evt_valid, evt_idx, evt_rise, level} !== {1'b1, 3'd0, 1'b1, 8'h01}) begin
         failures++;
         $display("FAIL post_reset_rise got=%b/%0d/%b/%h exp=1/0/1/01", evt_valid, evt_idx, evt_rise, level);
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_single got=%b exp=0", evt_valid);
      end
   endtask

   initial begin
      test_reset;
      test_single_rise;
      test_empty_ready;
`ifdef SW_DEBOUNCE_EN
      test_bounce;
`endif
      test_simultaneous;
      test_overflow;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
